// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - VGA receive-side checker: recovers pixel coordinates from the sync stream,
// checks line/frame timing, tracks lock and counts lit pixels per frame.

module vga_rx_monitor #(
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int LIT_THRESH  = 128,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic        vga_blank_n,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    output logic [9:0]  rx_x,
    output logic [9:0]  rx_y,
    output logic        rx_valid,
    output logic        rx_lit,
    output logic        frame_done,
    output logic [18:0] frame_lit,
    output logic        locked,
    output logic        err_hline,
    output logic        err_vframe,
    output logic        err_active
);

    localparam logic [9:0] H_ACTIVE_C = 10'(H_ACTIVE);
    localparam logic [9:0] H_TOTAL_C  = 10'(H_TOTAL);
    localparam logic [9:0] V_ACTIVE_C = 10'(V_ACTIVE);
    localparam logic [9:0] V_TOTAL_C  = 10'(V_TOTAL);
    localparam logic [7:0] LIT_C      = 8'(LIT_THRESH);
    localparam logic [7:0] LOCK_C     = 8'(LOCK_FRAMES);
    localparam logic [9:0] CNT_MAX    = 10'h3FF;

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  clean_q, clean_d;
    logic        dirty_q, dirty_d;

    logic        prev_hs, prev_vs;
    logic [9:0]  h_cnt, x_cnt, y_cnt, v_cnt;
    logic [18:0] lit_cnt;

    logic        hs_fall, vs_fall;
    logic        lit, pix_lit;
    logic        line_act;
    logic [9:0]  v_line, y_line;
    logic        frame_chk;
    logic        hline_err, hact_err, vframe_err, vact_err, any_err;
    logic [18:0] lit_sum;

    // Sync edges compare the previous registered level against the live input.
    assign hs_fall  = prev_hs & ~vga_hs;
    assign vs_fall  = prev_vs & ~vga_vs;

    assign lit      = (vga_r >= LIT_C) && (vga_g >= LIT_C) && (vga_b >= LIT_C);
    assign pix_lit  = lit & vga_blank_n;
    assign line_act = (x_cnt != 10'd0);

    // Line-end updates are folded in first so a coincident vsync sees the finished line.
    assign v_line = (hs_fall && v_cnt != CNT_MAX) ? v_cnt + 10'd1 : v_cnt;
    assign y_line = (hs_fall && line_act && y_cnt != CNT_MAX) ? y_cnt + 10'd1 : y_cnt;

    assign frame_chk  = vs_fall && (state_q != SEEK);
    assign hline_err  = hs_fall && (state_q != SEEK) && (h_cnt != H_TOTAL_C);
    assign hact_err   = hs_fall && line_act && (x_cnt != H_ACTIVE_C);
    assign vframe_err = frame_chk && (v_line != V_TOTAL_C);
    assign vact_err   = frame_chk && (y_line != V_ACTIVE_C);
    assign any_err    = hline_err | hact_err | vframe_err | vact_err;

    assign lit_sum = lit_cnt + 19'((pix_lit && lit_cnt != '1) ? 1 : 0);

    always_comb begin
        state_d = state_q;
        clean_d = clean_q;
        dirty_d = dirty_q;
        case (state_q)
            SEEK: begin
                if (vs_fall) begin
                    state_d = LOCKING;
                    clean_d = 8'd0;
                    dirty_d = 1'b0;
                end
            end
            LOCKING: begin
                if (vs_fall) begin
                    dirty_d = 1'b0;
                    if (any_err || dirty_q) begin
                        clean_d = 8'd0;
                    end else if ((clean_q + 8'd1) >= LOCK_C) begin
                        state_d = LOCKED;
                        clean_d = 8'd0;
                    end else begin
                        clean_d = clean_q + 8'd1;
                    end
                end else if (any_err) begin
                    clean_d = 8'd0;
                    dirty_d = 1'b1;
                end
            end
            LOCKED: begin
                // A mid-frame error taints the frame in progress; one on vsync does not carry over.
                if (any_err) begin
                    state_d = LOCKING;
                    clean_d = 8'd0;
                    dirty_d = ~vs_fall;
                end
            end
            default: begin
                state_d = SEEK;
                clean_d = 8'd0;
                dirty_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= SEEK;
            clean_q    <= 8'd0;
            dirty_q    <= 1'b0;
            prev_hs    <= 1'b0;
            prev_vs    <= 1'b0;
            h_cnt      <= 10'd0;
            x_cnt      <= 10'd0;
            y_cnt      <= 10'd0;
            v_cnt      <= 10'd0;
            lit_cnt    <= 19'd0;
            rx_x       <= 10'd0;
            rx_y       <= 10'd0;
            rx_valid   <= 1'b0;
            rx_lit     <= 1'b0;
            frame_done <= 1'b0;
            frame_lit  <= 19'd0;
            locked     <= 1'b0;
            err_hline  <= 1'b0;
            err_vframe <= 1'b0;
            err_active <= 1'b0;
        end else begin
            prev_hs <= vga_hs;
            prev_vs <= vga_vs;

            rx_x     <= x_cnt;
            rx_y     <= y_cnt;
            rx_valid <= vga_blank_n;
            rx_lit   <= pix_lit;

            if (hs_fall) begin
                h_cnt <= 10'd1;
            end else if (h_cnt != CNT_MAX) begin
                h_cnt <= h_cnt + 10'd1;
            end

            if (hs_fall) begin
                x_cnt <= 10'd0;
            end else if (vga_blank_n && x_cnt != CNT_MAX) begin
                x_cnt <= x_cnt + 10'd1;
            end

            if (vs_fall) begin
                y_cnt     <= 10'd0;
                v_cnt     <= 10'd0;
                frame_lit <= lit_sum;
                lit_cnt   <= 19'd0;
            end else begin
                y_cnt   <= y_line;
                v_cnt   <= v_line;
                lit_cnt <= lit_sum;
            end

            frame_done <= frame_chk;

            if (hline_err) begin
                err_hline <= 1'b1;
            end
            if (vframe_err) begin
                err_vframe <= 1'b1;
            end
            if (hact_err || vact_err) begin
                err_active <= 1'b1;
            end

            state_q <= state_d;
            clean_q <= clean_d;
            dirty_q <= dirty_d;
            locked  <= (state_d == LOCKED);
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb/tb_vga_rx_monitor.sv - directed bench for vga_rx_monitor on a scaled 16x8 (24x12 total) raster.

module tb_vga_rx_monitor;

    localparam int HA = 16;
    localparam int HT = 24;
    localparam int VA = 8;
    localparam int VT = 12;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        vga_hs = 1'b1;
    logic        vga_vs = 1'b1;
    logic        vga_blank_n = 1'b0;
    logic [7:0]  vga_r = 8'd0;
    logic [7:0]  vga_g = 8'd0;
    logic [7:0]  vga_b = 8'd0;
    logic [9:0]  rx_x, rx_y;
    logic        rx_valid, rx_lit, frame_done, locked;
    logic [18:0] frame_lit;
    logic        err_hline, err_vframe, err_active;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int fd_cnt = 0;
    int last_lit = -1;
    int t_fd = -1, t_lock = -1, t_err = -1, t_unlock = -2;
    logic prev_eh = 1'b0, prev_lk = 1'b0;
    logic first_found = 1'b0;
    int first_x = -1, first_y = -1;
    logic lit_map [0:VA-1][0:HA-1];

    vga_rx_monitor #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
        .LIT_THRESH(128), .LOCK_FRAMES(2)
    ) dut (
        .clock(clock), .reset(reset),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .rx_x(rx_x), .rx_y(rx_y), .rx_valid(rx_valid), .rx_lit(rx_lit),
        .frame_done(frame_done), .frame_lit(frame_lit), .locked(locked),
        .err_hline(err_hline), .err_vframe(err_vframe), .err_active(err_active)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    always @(negedge clock) begin
        cyc++;
        if (frame_done === 1'b1) begin
            fd_cnt++;
            last_lit = int'(frame_lit);
            t_fd = cyc;
        end
        if (rx_valid === 1'b1 && rx_lit === 1'b1 && !first_found) begin
            first_found = 1'b1;
            first_x = int'(rx_x);
            first_y = int'(rx_y);
        end
        if (rx_valid === 1'b1 && int'(rx_x) < HA && int'(rx_y) < VA)
            lit_map[int'(rx_y)][int'(rx_x)] = rx_lit;
        if (err_hline && !prev_eh) t_err = cyc;
        if (!locked && prev_lk) t_unlock = cyc;
        if (locked && !prev_lk) t_lock = cyc;
        prev_eh = err_hline;
        prev_lk = locked;
    end

    function automatic logic [23:0] pix(input int pattern, input int x, input int y);
        logic [23:0] p;
        p = 24'h000000;
        if (pattern == 1) begin
            if ((x >= 4 && x <= 7 && y >= 5 && y <= 6) || (x >= 10 && x <= 12 && y >= 1 && y <= 2))
                p = 24'hFFFFFF;
        end else if (pattern == 2 && y == 0) begin
            if (x == 0) p = {8'd127, 8'd255, 8'd255};
            if (x == 1) p = {8'd128, 8'd128, 8'd128};
            if (x == 2) p = {8'd255, 8'd255, 8'd127};
        end
        return p;
    endfunction

    task automatic drive(input logic hs, input logic vs, input logic bl, input logic [23:0] rgb);
        @(negedge clock);
        vga_hs = hs;
        vga_vs = vs;
        vga_blank_n = bl;
        {vga_r, vga_g, vga_b} = rgb;
    endtask

    // Line layout: active 0..act-1, hsync low at columns 18..21, line length len.
    task automatic send_line(input int y, input int len, input int act, input logic vs_low, input int pattern);
        for (int c = 0; c < len; c++) begin
            drive(!(c >= 18 && c < 22), !vs_low, c < act, (c < act) ? pix(pattern, c, y) : 24'h0);
        end
    endtask

    // Frame of n_lines lines; vsync low on lines n_lines-3 and n_lines-2.
    task automatic send_frame(input int n_lines, input int first, input int last,
                              input int short_line, input int narrow_line, input int pattern);
        for (int l = first; l <= last; l++) begin
            send_line(l, (l == short_line) ? HT - 1 : HT,
                      (l < VA) ? ((l == narrow_line) ? HA - 1 : HA) : 0,
                      (l == n_lines - 3) || (l == n_lines - 2), pattern);
        end
    endtask

    task automatic clear_map;
        for (int yy = 0; yy < VA; yy++)
            for (int xx = 0; xx < HA; xx++)
                lit_map[yy][xx] = 1'bx;
        first_found = 1'b0;
    endtask

    task automatic test_reset;
        repeat (4) drive(1'b1, 1'b1, 1'b0, 24'h0);
        checks++; if ({rx_x, rx_y, rx_valid, rx_lit, frame_done, frame_lit, locked} !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", {rx_x, rx_y, rx_valid, rx_lit, frame_done, frame_lit, locked}); end
        checks++; if ({err_hline, err_vframe, err_active} !== 3'b000) begin errors++; $display("FAIL reset_errs: got %b expected 000", {err_hline, err_vframe, err_active}); end
        reset = 1'b1;
    endtask

    task automatic test_nominal;
        t_lock = -1;
        for (int f = 0; f < 3; f++) send_frame(VT, 0, VT - 1, -1, -1, 0);
        checks++; if (fd_cnt !== 2) begin errors++; $display("FAIL nominal_frame_done: got %0d expected 2", fd_cnt); end
        checks++; if (last_lit !== 0) begin errors++; $display("FAIL nominal_frame_lit: got %0d expected 0", last_lit); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL nominal_locked: got %b expected 1", locked); end
        checks++; if (t_lock !== t_fd) begin errors++; $display("FAIL nominal_lock_time: got %0d expected %0d", t_lock, t_fd); end
        checks++; if ({err_hline, err_vframe, err_active} !== 3'b000) begin errors++; $display("FAIL nominal_errs: got %b expected 000", {err_hline, err_vframe, err_active}); end
    endtask

    task automatic test_pattern;
        int fd0;
        fd0 = fd_cnt;
        clear_map();
        send_frame(VT, 0, VT - 1, -1, -1, 1);
        checks++; if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL pattern_frame_done: got %0d expected %0d", fd_cnt, fd0 + 1); end
        checks++; if (last_lit !== 14) begin errors++; $display("FAIL pattern_frame_lit: got %0d expected 14", last_lit); end
        checks++; if (first_x !== 10 || first_y !== 1) begin errors++; $display("FAIL pattern_first_lit: got x=%0d y=%0d expected x=10 y=1", first_x, first_y); end
        checks++; if (lit_map[5][4] !== 1'b1 || lit_map[6][7] !== 1'b1) begin errors++; $display("FAIL pattern_bar_lit: got %b%b expected 11", lit_map[5][4], lit_map[6][7]); end
        checks++; if (lit_map[4][4] !== 1'b0 || lit_map[5][8] !== 1'b0 || lit_map[5][3] !== 1'b0) begin errors++; $display("FAIL pattern_bar_edges: got %b%b%b expected 000", lit_map[4][4], lit_map[5][8], lit_map[5][3]); end
    endtask

    task automatic test_threshold;
        clear_map();
        send_frame(VT, 0, VT - 1, -1, -1, 2);
        checks++; if (lit_map[0][0] !== 1'b0) begin errors++; $display("FAIL thresh_127: got %b expected 0", lit_map[0][0]); end
        checks++; if (lit_map[0][1] !== 1'b1) begin errors++; $display("FAIL thresh_128: got %b expected 1", lit_map[0][1]); end
        checks++; if (lit_map[0][2] !== 1'b0) begin errors++; $display("FAIL thresh_blue127: got %b expected 0", lit_map[0][2]); end
        checks++; if (last_lit !== 1) begin errors++; $display("FAIL thresh_frame_lit: got %0d expected 1", last_lit); end
        checks++; if (locked !== 1'b1 || {err_hline, err_vframe, err_active} !== 3'b000) begin errors++; $display("FAIL thresh_state: got locked=%b errs=%b expected 1 000", locked, {err_hline, err_vframe, err_active}); end
    endtask

    task automatic test_short_line;
        t_err = -1;
        t_unlock = -2;
        send_frame(VT, 0, VT - 1, 2, -1, 0);
        checks++; if (err_hline !== 1'b1) begin errors++; $display("FAIL shortline_err: got %b expected 1", err_hline); end
        checks++; if (t_unlock !== t_err) begin errors++; $display("FAIL shortline_unlock_time: got %0d expected %0d", t_unlock, t_err); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL shortline_unlocked: got %b expected 0", locked); end
        send_frame(VT, 0, VT - 1, -1, -1, 0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL shortline_one_clean: got %b expected 0", locked); end
        send_frame(VT, 0, VT - 1, -1, -1, 0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL shortline_relock: got %b expected 1", locked); end
        checks++; if ({err_hline, err_vframe, err_active} !== 3'b100) begin errors++; $display("FAIL shortline_sticky: got %b expected 100", {err_hline, err_vframe, err_active}); end
    endtask

    task automatic test_short_frame;
        int fd0;
        fd0 = fd_cnt;
        send_frame(VT - 1, 0, VT - 2, -1, -1, 0);
        checks++; if (err_vframe !== 1'b1) begin errors++; $display("FAIL shortframe_err: got %b expected 1", err_vframe); end
        checks++; if (err_active !== 1'b0) begin errors++; $display("FAIL shortframe_active: got %b expected 0", err_active); end
        checks++; if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL shortframe_done: got %0d expected %0d", fd_cnt, fd0 + 1); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL shortframe_unlock: got %b expected 0", locked); end
    endtask

    task automatic test_narrow_line;
        int fd0;
        fd0 = fd_cnt;
        send_frame(VT, 0, VT - 1, -1, 3, 0);
        checks++; if (err_active !== 1'b1) begin errors++; $display("FAIL narrow_err: got %b expected 1", err_active); end
        checks++; if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL narrow_done: got %0d expected %0d", fd_cnt, fd0 + 1); end
    endtask

    task automatic test_reset_midline;
        int fd0;
        send_frame(VT, 0, VT - 1, -1, -1, 1);
        checks++; if (frame_lit !== 19'd14) begin errors++; $display("FAIL midreset_pre_lit: got %0d expected 14", frame_lit); end
        for (int c = 0; c <= 6; c++) drive(1'b1, 1'b1, 1'b1, pix(1, c, 5));
        @(posedge clock);
        #1;
        checks++; if (rx_x !== 10'd6 || rx_valid !== 1'b1 || rx_lit !== 1'b1) begin errors++; $display("FAIL midreset_pre_pixel: got x=%0d v=%b l=%b expected x=6 v=1 l=1", rx_x, rx_valid, rx_lit); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if ({rx_x, rx_y, rx_valid, rx_lit, frame_done, frame_lit, locked} !== '0) begin errors++; $display("FAIL midreset_outputs: got %h expected 0", {rx_x, rx_y, rx_valid, rx_lit, frame_done, frame_lit, locked}); end
        checks++; if ({err_hline, err_vframe, err_active} !== 3'b000) begin errors++; $display("FAIL midreset_errs: got %b expected 000", {err_hline, err_vframe, err_active}); end
        repeat (3) drive(1'b1, 1'b1, 1'b0, 24'h0);
        reset = 1'b1;
        fd0 = fd_cnt;
        send_frame(VT, 0, VT - 2, -1, -1, 0);
        checks++; if (fd_cnt !== fd0) begin errors++; $display("FAIL midreset_no_done: got %0d expected %0d", fd_cnt, fd0); end
        checks++; if ({err_hline, err_vframe, err_active, locked} !== 4'b0000) begin errors++; $display("FAIL midreset_partial_clean: got %b expected 0000", {err_hline, err_vframe, err_active, locked}); end
        send_frame(VT, VT - 1, VT - 1, -1, -1, 0);
        send_frame(VT, 0, VT - 1, -1, -1, 0);
        checks++; if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL midreset_second_done: got %0d expected %0d", fd_cnt, fd0 + 1); end
        checks++; if ({err_hline, err_vframe, err_active} !== 3'b000 || frame_lit !== 19'd0) begin errors++; $display("FAIL midreset_second_state: got errs=%b lit=%0d expected 000 0", {err_hline, err_vframe, err_active}, frame_lit); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_pattern();
        test_threshold();
        test_short_line();
        test_short_frame();
        test_narrow_line();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_rx_monitor.md
Name: vga_rx_monitor

Overview:
- Receive-side counterpart of the VGA timing generator. Consumes the HS/VS/BLANK_N sync stream plus pixel RGB and recovers pixel coordinates.
- Checks 640x480 timing and reports sticky errors, a lock flag and per-frame lit-pixel statistics.
- Sits beside the video path on VGA_CLK as an on-chip checker. Bench use and SignalTap observation; also future screen-content checks such as ball/bar presence.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, clocks per line (sync-to-sync)
- V_ACTIVE, 480, active lines per frame
- V_TOTAL, 525, lines per frame (vsync-to-vsync)
- LIT_THRESH, 128, per-channel threshold for a pixel to count as lit
- LOCK_FRAMES, 2, consecutive clean frames required for lock

Ports:
- clock  in  1  pixel clock (VGA_CLK domain)
- reset  in  1  asynchronous, active-low
- vga_hs  in  1  horizontal sync, active-low
- vga_vs  in  1  vertical sync, active-low
- vga_blank_n  in  1  high = active video
- vga_r  in  8  red
- vga_g  in  8  green
- vga_b  in  8  blue
- rx_x  out  10  recovered column of sampled pixel
- rx_y  out  10  recovered row of sampled pixel
- rx_valid  out  1  rx_x/rx_y/rx_lit describe an active pixel
- rx_lit  out  1  sampled pixel is lit
- frame_done  out  1  one-cycle pulse at end of each frame
- frame_lit  out  19  lit-pixel count of last completed frame
- locked  out  1  timing locked
- err_hline  out  1  sticky: line period != H_TOTAL
- err_vframe  out  1  sticky: frame line count != V_TOTAL
- err_active  out  1  sticky: active pixels/line != H_ACTIVE, or active lines/frame != V_ACTIVE

Behaviour:
- Reset (reset=0, async): all outputs 0; all counters 0; state SEEK.
- Edge detect: inputs registered once. hs_fall = prev_hs & ~hs; vs_fall likewise.
- Pixel is lit when vga_r, vga_g and vga_b are all >= LIT_THRESH.
- h_cnt (10b):
  - Cleared to 1 on hs_fall; otherwise +1.
  - Saturates at 1023.
- x_cnt:
  - Cleared on hs_fall.
  - +1 per cycle with blank_n=1.
- Pixel outputs: a pixel sampled on cycle N appears on cycle N+1, giving latency 1. rx_x = x_cnt before increment (first active pixel of a line -> 0), rx_y = y_cnt, rx_valid = blank_n, rx_lit = lit & blank_n.
- Line end (hs_fall):
  - If state != SEEK and h_cnt != H_TOTAL: set err_hline.
  - If line had any active pixel and x_cnt != H_ACTIVE: set err_active.
  - If line had any active pixel: y_cnt +1.
  - v_cnt +1, saturating at 1023.
- Frame end (vs_fall):
  - frame_done pulses next cycle.
  - frame_lit latches the running lit count, which then clears. The count is 19b and cannot overflow: 307200 max.
  - If state is LOCKING or LOCKED:
    - v_cnt != V_TOTAL: set err_vframe.
    - y_cnt != V_ACTIVE: set err_active.
  - y_cnt and v_cnt clear.
  - A vs_fall and hs_fall in the same cycle are processed as line end first, then frame end.
- State machine (SEEK, LOCKING, LOCKED):
  - SEEK -> LOCKING on first vs_fall. No frame checks are made on that first partial frame, and no frame_done is issued.
  - LOCKING: count clean frames. A clean frame is one in which no error is raised during the frame. After LOCK_FRAMES clean frames -> LOCKED and locked=1. Any error -> clean count 0, stay LOCKING.
  - LOCKED: any new error -> LOCKING, locked=0 on the next cycle.
- Error flags are sticky until reset. Losing lock does not clear them.
- Reset mid-frame returns to SEEK. Partial-frame data is discarded and frame_lit=0.

Test Plan:
- Nominal 800x525 stream with all pixels black, 3 frames -> frame_done 2 pulses (frames 2, 3); frame_lit=0; locked=1 one cycle after 3rd vs_fall; no err_* set.
- White 128x16 bar at x 256..383, y 456..471 plus 177-pixel ball, all RGB=255 -> frame_lit=2225; first lit pixel reports rx_x=256, rx_y=456, rx_lit=1.
- Pixel at RGB=(127,255,255) -> rx_lit=0. RGB=(128,128,128) -> rx_lit=1.
- One line shortened to 799 clocks while LOCKED -> err_hline=1 at that hs_fall; locked drops next cycle; relocks after 2 clean frames; err_hline stays 1.
- Frame with 524 lines; separately, one line with 639 blank_n cycles -> err_vframe=1 and err_active=1 respectively; frame_done still pulses.
- reset asserted mid-line at x=300 -> all outputs 0 immediately. Release, then a partial first frame -> no frame_done and no errors until the second vs_fall.
